// File: rtl/uart_tx_frm.sv
// uart_tx_frm: FIFO-buffered UART transmitter with a runtime baud divisor,
// 5..8 data bits, optional even/odd parity and one or two stop bits.
// Framing configuration is captured when each byte is loaded, so the host
// may reprogram it between bytes without disturbing the frame on the line.
module uart_tx_frm #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  data_bits,
    input  logic [1:0]                  par_mode,
    input  logic                        two_stop,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        TX,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;

    // Byte FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_nxt;

    // Per-frame registers, captured at load
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] baud_cnt;
    logic [1:0]       dbits_q;
    logic [1:0]       par_q;
    logic             two_q;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic             par_acc;
    logic             stop_idx;

    // Decoded helpers
    logic       push;
    logic       pop;
    logic       bit_end;
    logic       last_stop;
    logic       frame_end;
    logic       idle_nxt;
    logic       par_en;
    logic [2:0] last_idx;

    // Combinational decode of bit boundaries, FIFO handshakes and next count
    // NOTE: every signal here is assigned on every pass, so no latch can form.
    always_comb begin
        bit_end   = (baud_cnt == div_q);
        last_stop = !two_q || stop_idx;
        frame_end = (state == STOP) && bit_end && last_stop;
        par_en    = (par_q == 2'd1) || (par_q == 2'd2);
        last_idx  = {1'b0, dbits_q} + 3'd4;
        push      = tx_valid && tx_ready;
        // A byte leaves the FIFO either from idle or straight out of the
        // final stop bit, which is what makes back-to-back frames gapless.
        pop       = ((state == IDLE) || frame_end) && (fifo_cnt != '0);
        idle_nxt  = ((state == IDLE) || frame_end) && !pop;
        cnt_nxt   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end

    // FIFO storage write
    // NOTE: the data array is deliberately not reset; pointers and count
    // alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready/busy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= cnt_nxt;
            tx_ready <= (cnt_nxt != CNT_W'(FIFO_DEPTH));
            busy     <= !idle_nxt || (cnt_nxt != '0);
        end
    end

    // Frame sequencer: drives TX and the tx_done pulse as registered outputs
    // NOTE: all state updates use non-blocking assignment so every register
    // sees pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            TX       <= 1'b1;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            div_q    <= '0;
            dbits_q  <= '0;
            par_q    <= '0;
            two_q    <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            par_acc  <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                // Load the next byte and its framing, then begin the start bit
                state    <= START;
                TX       <= 1'b0;
                shreg    <= mem[rd_ptr];
                div_q    <= baud_div;
                dbits_q  <= data_bits;
                par_q    <= par_mode;
                two_q    <= two_stop;
                baud_cnt <= '0;
                bit_idx  <= '0;
                par_acc  <= 1'b0;
                stop_idx <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        TX <= 1'b1;
                    end

                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            baud_cnt <= '0;
                            TX       <= shreg[0];
                            shreg    <= shreg >> 1;
                            par_acc  <= par_acc ^ shreg[0];
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end

                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == last_idx) begin
                                if (par_en) begin
                                    state <= PARITY;
                                    // par_acc already holds XOR of all sent bits
                                    TX    <= par_acc ^ (par_q == 2'd2);
                                end else begin
                                    state    <= STOP;
                                    TX       <= 1'b1;
                                    stop_idx <= 1'b0;
                                    // With 1-cycle bits the lone stop bit is
                                    // also the last cycle of the frame.
                                    tx_done  <= !two_q && (div_q == '0);
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                TX      <= shreg[0];
                                shreg   <= shreg >> 1;
                                par_acc <= par_acc ^ shreg[0];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end

                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            baud_cnt <= '0;
                            TX       <= 1'b1;
                            stop_idx <= 1'b0;
                            tx_done  <= !two_q && (div_q == '0);
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                        end
                    end

                    STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (!last_stop) begin
                                stop_idx <= 1'b1;
                                tx_done  <= (div_q == '0);
                            end else begin
                                // Frame over and nothing queued
                                state <= IDLE;
                                TX    <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + DIV_W'(1);
                            // Raise tx_done so it lines up with the final cycle
                            tx_done  <= last_stop && ((baud_cnt + DIV_W'(1)) == div_q);
                        end
                    end

                    default: begin
                        state <= IDLE;
                        TX    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frm.sv
// tb_uart_tx_frm: directed stimulus with a frame scoreboard. Each pushed
// byte queues its expected serial frame; a monitor pops and compares every
// bit, its duration, the tx_done pulse and inter-frame gaps.
module tb_uart_tx_frm;

    localparam int DIV_W = 16;
    localparam int DEPTH = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [DIV_W-1:0]           baud_div;
    logic [1:0]                 data_bits;
    logic [1:0]                 par_mode;
    logic                       two_stop;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       tx_line;
    logic                       busy;
    logic                       tx_done;
    logic [$clog2(DEPTH):0]     fifo_cnt;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          period;
        bit          contig;
        int          exp_start;
    } frame_t;

    frame_t sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int frames_seen = 0;
    int mon_last_start = -1;
    int mon_last_end = -1;
    int mon_last_done = -1;

    int cur_div, cur_dbits, cur_par, cur_two;

    uart_tx_frm #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_div  (baud_div),
        .data_bits (data_bits),
        .par_mode  (par_mode),
        .two_stop  (two_stop),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .TX        (tx_line),
        .busy      (busy),
        .tx_done   (tx_done),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference framing: start, D data bits LSB first, optional parity, stops
    function automatic frame_t mk_frame(input logic [7:0] d, input int dbits, input int par,
                                        input int two, input int div, input bit contig,
                                        input int exp_start);
        frame_t f;
        int     n;
        logic   p;
        n = 0;
        p = 1'b0;
        f.bits = '0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < dbits + 5; i++) begin
            f.bits[n] = d[i];
            p = p ^ d[i];
            n++;
        end
        if (par == 1) begin
            f.bits[n] = p;
            n++;
        end else if (par == 2) begin
            f.bits[n] = ~p;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (two != 0) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits     = n;
        f.period    = div + 1;
        f.contig    = contig;
        f.exp_start = exp_start;
        return f;
    endfunction

    task automatic set_cfg(input int div, input int dbits, input int par, input int two);
        cur_div   = div;
        cur_dbits = dbits;
        cur_par   = par;
        cur_two   = two;
        baud_div  = DIV_W'(div);
        data_bits = 2'(dbits);
        par_mode  = 2'(par);
        two_stop  = (two != 0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push_byte(input logic [7:0] d, output int acc_cyc, output int stall);
        int waited;
        waited = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("push_ready_wait_in_bound", waited < 1000, 1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        stall    = waited;
        tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit contig, input bit chk_lat,
                        output int acc_cyc, output int stall);
        push_byte(d, acc_cyc, stall);
        sb.push_back(mk_frame(d, cur_dbits, cur_par, cur_two, cur_div, contig,
                              chk_lat ? acc_cyc + 1 : -1));
    endtask

    task automatic wait_idle(input int bound, output int idle_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_bound", n < bound, 1);
        idle_cyc = cyc;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: a falling TX while running marks a start bit
    initial begin : monitor
        frame_t f;
        bit     aborted;
        bit     bad;
        bit     done_bad;
        logic   done_last;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_line === 1'b0) begin
                if (sb.size() == 0) begin
                    check("start_with_empty_scoreboard", sb.size(), 1);
                    while (tx_line === 1'b0 && rst_n === 1'b1) @(negedge clk);
                end else begin
                    f = sb.pop_front();
                    if (f.exp_start >= 0) check("start_latency", cyc, f.exp_start);
                    if (f.contig) check("no_idle_gap", cyc, mon_last_end + 1);
                    mon_last_start = cyc;
                    aborted   = 1'b0;
                    done_bad  = 1'b0;
                    done_last = 1'b0;
                    for (int i = 0; i < f.nbits && !aborted; i++) begin
                        bad = 1'b0;
                        for (int c = 0; c < f.period && !aborted; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                if (tx_line !== f.bits[i]) bad = 1'b1;
                                if (i == f.nbits - 1 && c == f.period - 1) done_last = tx_done;
                                else if (tx_done !== 1'b0) done_bad = 1'b1;
                            end
                        end
                        if (!aborted) check($sformatf("frame_bit%0d", i), bad, 0);
                    end
                    if (!aborted) begin
                        check("tx_done_last_cycle", done_last, 1);
                        check("tx_done_not_early", done_bad, 0);
                        mon_last_end = cyc;
                        if (done_last === 1'b1) mon_last_done = cyc;
                        frames_seen++;
                    end
                end
            end
        end
    end

    initial begin : stim
        int acc;
        int acc1;
        int stall;
        int idle_cyc;
        int start_s;
        int n;
        logic [7:0] burst [6];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(3, 3, 0, 0);
        rst_n = 1'b0;
        #12;
        check("reset_tx", tx_line, 1);
        check("reset_tx_done", tx_done, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_fifo_cnt", fifo_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 4-cycle bits, 0xA5
        send(8'hA5, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        check("8n1_frame_len", mon_last_end - mon_last_start + 1, 40);
        check("8n1_busy_falls_after_done", idle_cyc, mon_last_done + 1);
        check("8n1_done_pulses", done_cnt, 1);

        // 7E2 and 7O2
        set_cfg(3, 2, 1, 1);
        send(8'h83, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        send(8'h07, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        set_cfg(3, 2, 2, 1);
        send(8'h03, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        check("7o2_frame_len", mon_last_end - mon_last_start + 1, 44);

        // 5-bit data, upper bits ignored
        set_cfg(3, 0, 0, 0);
        send(8'hFF, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        check("5n1_frame_len", mon_last_end - mon_last_start + 1, 28);
        check("5n1_busy_falls_after_done", idle_cyc, mon_last_done + 1);

        // Burst of 6 into a 4-deep FIFO, 2-cycle bits
        set_cfg(1, 3, 0, 0);
        send(burst[0], 1'b0, 1'b1, acc, stall);
        for (int k = 1; k < 5; k++) send(burst[k], 1'b1, 1'b0, acc, stall);
        check("burst_full_cnt", fifo_cnt, 4);
        check("burst_full_not_ready", tx_ready, 0);
        send(burst[5], 1'b1, 1'b0, acc, stall);
        check("burst_stalled", stall > 0, 1);
        check("burst_accept_after_pop", acc, mon_last_end + 2);
        wait_idle(2000, idle_cyc);
        check("burst_done_pulses", done_cnt, 11);

        // Mid-frame divisor change: frame 1 keeps 4-cycle bits, frame 2 uses 8
        set_cfg(3, 3, 0, 0);
        send(8'h3C, 1'b0, 1'b1, acc1, stall);
        push_byte(8'hC3, acc, stall);
        sb.push_back(mk_frame(8'hC3, 3, 0, 0, 7, 1'b1, -1));
        repeat (8) @(negedge clk);
        set_cfg(7, 3, 0, 0);
        wait_idle(1000, idle_cyc);
        check("reconfig_frame2_len", mon_last_end - mon_last_start + 1, 80);
        check("reconfig_done_pulses", done_cnt, 13);

        // Async reset in the parity bit of a 7E1 frame with a byte queued
        set_cfg(3, 2, 1, 0);
        send(8'h55, 1'b0, 1'b1, acc, stall);
        start_s = acc + 1;
        push_byte(8'hAA, acc, stall);
        sb.push_back(mk_frame(8'hAA, 2, 1, 0, 3, 1'b1, -1));
        n = 0;
        while (cyc < start_s + 33 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_parity_in_bound", n < 200, 1);
        check("parity_bit_before_reset", tx_line, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx_line, 1);
        check("async_reset_fifo_cnt", fifo_cnt, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_tx_ready", tx_ready, 1);
        check("async_reset_tx_done", tx_done, 0);
        @(negedge clk);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_cfg(3, 3, 0, 0);
        send(8'h55, 1'b0, 1'b1, acc, stall);
        wait_idle(400, idle_cyc);
        check("post_reset_frame_len", mon_last_end - mon_last_start + 1, 40);

        check("total_done_pulses", done_cnt, 14);
        check("total_frames_seen", frames_seen, 14);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
